// File: rtl/pipeline_controller.sv
// Pipeline hazard and memory-wait controller for a five-stage in-order core.
// Decodes per-stage write enables and bubble inserts from the current state and
// hazard inputs, tracks data-memory waits with a timeout, and keeps cycle/stall
// performance counters.
module pipeline_controller #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_stall,
    input  logic             ex_redirect,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALTED   = 2'b10
    } state_e;

    localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    state_e     dec_state;
    logic [7:0] wcnt_inc;
    logic       mem_blocked;

    // While reset is held the enables behave as if the pipeline were running,
    // regardless of what the state register still contains.
    assign dec_state   = rst ? RUN : state_q;
    assign mem_blocked = mem_req && !mem_ready;
    assign wcnt_inc    = wcnt_q + 8'd1;

    // Enable/flush decode: a memory wait freezes everything but drains MEM into
    // WB as a bubble; otherwise redirect beats load-use beats fetch miss.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        case (dec_state)
            HALTED: begin
            end
            MEM_WAIT: begin
                memwb_we    = 1'b1;
                memwb_flush = 1'b1;
            end
            default: begin
                if (mem_blocked) begin
                    memwb_we    = 1'b1;
                    memwb_flush = 1'b1;
                end else if (ex_redirect) begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_stall) begin
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    idex_flush = 1'b1;
                end else if (!imem_ready) begin
                    ifid_we    = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_we    = 1'b1;
                    ifid_we  = 1'b1;
                    idex_we  = 1'b1;
                    exmem_we = 1'b1;
                    memwb_we = 1'b1;
                end
            end
        endcase
    end

    // Next-state, wait-timeout and counter computation; halt_req overrides any
    // other transition, and only reset leaves HALTED.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        mem_timeout_d = mem_timeout_q;
        cycle_cnt_d   = cycle_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_blocked) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == MAX_WAIT_C) begin
                        mem_timeout_d = 1'b1;
                        state_d       = HALTED;
                    end
                end
            end
            default: begin
            end
        endcase
        if (halt_req) begin
            state_d = HALTED;
        end
        if (state_q != HALTED) begin
            cycle_cnt_d = cycle_cnt_q + CNT_ONE;
            if (!pc_we) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
        end
    end

    // State, wait counter, sticky timeout and counters with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wcnt_q        <= 8'd0;
            mem_timeout_q <= 1'b0;
            cycle_cnt_q   <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            mem_timeout_q <= mem_timeout_d;
            cycle_cnt_q   <= cycle_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, meaning the maximum consecutive MEM-wait cycles before timeout (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the performance counters.
REQ-003 SHALL have a single clock, clk; reset is synchronous and active-high, named rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load_stall  input  1  load-use hazard from the hazard detection unit (ID depends on a load in EX).
REQ-007 ex_redirect  input  1  taken branch, jal or jalr resolved in EX.
REQ-008 imem_ready  input  1  instruction memory has returned valid data this cycle.
REQ-009 mem_req  input  1  MEM stage holds a load or store.
REQ-010 mem_ready  input  1  data memory completes the MEM access this cycle.
REQ-011 halt_req  input  1  ecall/ebreak has reached WB.
REQ-012 pc_we, ifid_we, idex_we, exmem_we, memwb_we  output  1 each  pipeline register write enables.
REQ-013 ifid_flush, idex_flush, memwb_flush  output  1 each  insert a bubble (NOP) into that register on its write.
REQ-014 state  output  2  RUN=00, MEM_WAIT=01, HALTED=10.
REQ-015 mem_timeout  output  1  sticky error flag.
REQ-016 cycle_cnt, stall_cnt  output  CNT_W each  performance counters.

Function
REQ-017 RUN, mem_req=1 and mem_ready=0: SHALL enter MEM_WAIT next cycle; in this cycle the MEM-wait output set applies.
REQ-018 MEM-wait output set (RUN with mem_req=1 and mem_ready=0, and all of MEM_WAIT): pc/ifid/idex/exmem_we=0, memwb_we=1, memwb_flush=1, other flushes 0.
REQ-019 MEM_WAIT: mem_ready=1 SHALL return to RUN next cycle; that cycle is still frozen; advance resumes in RUN.
REQ-020 SHALL keep wait counter wcnt (8 bit), cleared on entry to MEM_WAIT and incremented each MEM_WAIT cycle with mem_ready=0.
REQ-021 wcnt reaching MAX_WAIT with mem_ready=0 SHALL set mem_timeout=1 and enter HALTED next cycle.
REQ-022 RUN without MEM wait SHALL apply the first matching rule in this priority order: ex_redirect, load_stall, imem_ready=0, none.
REQ-023 ex_redirect: all we=1, ifid_flush=1, idex_flush=1; load_stall and imem_ready are ignored.
REQ-024 load_stall: pc_we=0, ifid_we=0, idex_we=1, idex_flush=1, exmem/memwb_we=1.
REQ-025 imem_ready=0: pc_we=0, ifid_we=1, ifid_flush=1, rest advance.
REQ-026 none: all we=1, all flushes 0.
REQ-027 halt_req=1 in any state SHALL enter HALTED next cycle and takes priority over every other transition.
REQ-028 HALTED: all we=0, all flushes 0; the state is left only by rst.
REQ-029 All outputs other than the counters, state and mem_timeout SHALL be combinational from the current state and inputs.
REQ-030 cycle_cnt SHALL increment every cycle outside HALTED.
REQ-031 stall_cnt SHALL increment in each non-HALTED cycle with pc_we=0.
REQ-032 Both counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-033 rst=1 at any edge SHALL set state=RUN, wcnt=0, mem_timeout=0, cycle_cnt=0 and stall_cnt=0, overriding halt_req and an in-progress MEM_WAIT.
REQ-034 With rst held high, outputs SHALL follow the RUN decode of the current inputs.

Verification
REQ-035 load_stall=1 for 1 cycle in RUN -> pc_we=0, ifid_we=0, idex_flush=1 for exactly 1 cycle; stall_cnt +1.
REQ-036 ex_redirect=1 and load_stall=1 together -> ifid_flush=1, idex_flush=1, pc_we=1; stall_cnt unchanged.
REQ-037 mem_req=1, mem_ready=0 for 3 cycles then 1 -> exmem_we=0 and memwb_flush=1 for 4 cycles; state 01 for cycles 2-4; RUN on cycle 5; stall_cnt +4.
REQ-038 MAX_WAIT=4, mem_ready held 0 -> mem_timeout=1 and state=10 after the 4th MEM_WAIT cycle; all we=0 afterwards.
REQ-039 halt_req=1 during MEM_WAIT -> HALTED next cycle; cycle_cnt frozen; rst pulse -> state=00 and counters=0.
REQ-040 CNT_W=4, 16 RUN cycles -> cycle_cnt wraps from 15 to 0.
